// File: rtl/ssds_pkg.sv
// Shared definitions for the SSD display path (bus interface, digit mapper,
// scan driver).
//   DIGIT_COUNT  number of multiplexed digits on the physical display
//   IDX_W        width of a digit index
//   state_e      scan driver FSM states
//   SEG_A..SEG_G bit positions of the segments inside a 7-bit pattern
package ssds_pkg;
  localparam int DIGIT_COUNT = 4;
  localparam int IDX_W       = $clog2(DIGIT_COUNT);
  localparam int SEG_W       = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
endpackage

// File: rtl/ssds_slot_timer.sv
// Modulo-DIGIT_PERIOD slot counter for the scan driver.
//   clk_i         system clock
//   rst_ni        synchronous active-low reset
//   clear_i       forces the count to 0 on the next edge (wins over enable_i)
//   enable_i      advance the count by one each cycle, wrapping at DIGIT_PERIOD-1
//   blank_done_o  count is on the last blanking cycle of the slot
//   slot_done_o   count is on the last cycle of the slot
module ssds_slot_timer #(
  parameter int DIGIT_PERIOD = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic blank_done_o,
  output logic slot_done_o
);
  localparam int CW = $clog2(DIGIT_PERIOD);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_PERIOD - 1);
  // With blanking disabled the strobe is never raised, so the value is moot.
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == SLOT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign slot_done_o  = enable_i && (cnt_q == SLOT_LAST);
  assign blank_done_o = (BLANK_CYCLES > 0) && enable_i && (cnt_q == BLANK_LAST);
endmodule

// File: rtl/ssds_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-segment 7-segment display.
// Scans the digits cyclically with a blanking gap at the start of each slot
// and shows a frame-consistent snapshot of the input patterns.
//   clk          system clock
//   rst          synchronous active-low reset
//   en           display enable
//   digit_0..3   segment patterns, bit0=a .. bit6=g, 1=lit
//   dots         decimal points, bit i belongs to digit i, 1=lit
//   seg, dp      shared segment / decimal-point pins (SEG_ACTIVE_LOW polarity)
//   sel          digit-select pins, one-hot when active (SEL_ACTIVE_LOW polarity)
//   frame_tick   pulse on the last cycle of digit 3's slot
module ssds_scan_driver
  import ssds_pkg::*;
#(
  parameter int DIGIT_PERIOD   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] digit_0,
  input  logic [6:0] digit_1,
  input  logic [6:0] digit_2,
  input  logic [6:0] digit_3,
  input  logic [3:0] dots,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] sel,
  output logic       frame_tick
);
  // Slot entry state: skip BLANK entirely when blanking is disabled.
  localparam state_e SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [SEG_W-1:0] shadow_q [DIGIT_COUNT];
  logic [3:0]       dots_q;

  logic [SEG_W-1:0] digit_in [DIGIT_COUNT];
  logic             blank_done, slot_done;
  logic [SEG_W-1:0] lit_seg;
  logic             lit_dp;
  logic [3:0]       lit_sel;
  logic             tick;
  logic             last_digit;

  assign digit_in[0] = digit_0;
  assign digit_in[1] = digit_1;
  assign digit_in[2] = digit_2;
  assign digit_in[3] = digit_3;

  function automatic logic [6:0] seg_pin(input logic [6:0] lit);
    return (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  function automatic logic dp_pin(input logic lit);
    return (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  function automatic logic [3:0] sel_pin(input logic [3:0] on);
    return (SEL_ACTIVE_LOW != 0) ? ~on : on;
  endfunction

  // Counter runs only while scanning; held at 0 in IDLE and on disable.
  ssds_slot_timer #(
    .DIGIT_PERIOD(DIGIT_PERIOD),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clear_i     (!en || (state_q == IDLE)),
    .enable_i    (state_q != IDLE),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done)
  );

  assign last_digit = (idx_q == IDX_W'(DIGIT_COUNT - 1));

  // Active-high view of what the pins should show for the current state.
  // seg/dp already carry the digit during BLANK so only sel gates the light.
  always_comb begin
    lit_seg = '0;
    lit_dp  = 1'b0;
    lit_sel = '0;
    tick    = 1'b0;
    if (state_q != IDLE) begin
      lit_seg = shadow_q[idx_q];
      lit_dp  = dots_q[idx_q];
    end
    if (state_q == SHOW) begin
      lit_sel = 4'b0001 << idx_q;
      tick    = last_digit && slot_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dots_q     <= '0;
      for (int i = 0; i < DIGIT_COUNT; i++) shadow_q[i] <= '0;
      seg        <= seg_pin('0);
      dp         <= dp_pin(1'b0);
      sel        <= sel_pin('0);
      frame_tick <= 1'b0;
    end else if (!en) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seg        <= seg_pin('0);
      dp         <= dp_pin(1'b0);
      sel        <= sel_pin('0);
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_pin(lit_seg);
      dp         <= dp_pin(lit_dp);
      sel        <= sel_pin(lit_sel);
      frame_tick <= tick;
      case (state_q)
        IDLE: begin
          for (int i = 0; i < DIGIT_COUNT; i++) shadow_q[i] <= digit_in[i];
          dots_q  <= dots;
          idx_q   <= '0;
          state_q <= SLOT_START;
        end
        BLANK: begin
          if (blank_done) state_q <= SHOW;
        end
        SHOW: begin
          if (slot_done) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= SLOT_START;
            // Frame boundary: refresh the snapshot so a frame never tears.
            if (last_digit) begin
              for (int i = 0; i < DIGIT_COUNT; i++) shadow_q[i] <= digit_in[i];
              dots_q <= dots;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ssds_scan_driver.sv
module tb_ssds_scan_driver;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [6:0] d0, d1, d2, d3;
  logic [3:0] dots;

  // dut 0: period 8, blank 2, active-low; dut 1: blank 0; dut 2: active-high
  logic [6:0] seg_a, seg_z, seg_h;
  logic       dp_a, dp_z, dp_h;
  logic [3:0] sel_a, sel_z, sel_h;
  logic       ft_a, ft_z, ft_h;

  always #5 clk = ~clk;

  ssds_scan_driver #(.DIGIT_PERIOD(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3),
    .dots(dots), .seg(seg_a), .dp(dp_a), .sel(sel_a), .frame_tick(ft_a));
  ssds_scan_driver #(.DIGIT_PERIOD(8), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_z (
    .clk(clk), .rst(rst), .en(en), .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3),
    .dots(dots), .seg(seg_z), .dp(dp_z), .sel(sel_z), .frame_tick(ft_z));
  ssds_scan_driver #(.DIGIT_PERIOD(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3),
    .dots(dots), .seg(seg_h), .dp(dp_h), .sel(sel_h), .frame_tick(ft_h));

  typedef struct packed {
    logic [2:0][6:0] seg;
    logic [2:0]      dp;
    logic [2:0][3:0] sel;
    logic [2:0]      ft;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Expectation tracking: t counts output edges since the enable edge.
  bit         run = 1'b0;
  int         t = 0;
  logic [6:0] snap [4];
  logic [3:0] snap_dots;

  // Closed-form expectation: slot = t/8 mod 4, phase = t mod 8,
  // phases 0..1 blank (except the no-blank build), tick on t mod 32 == 31.
  function automatic exp_t build(input bit active, input int tt);
    exp_t       e;
    int         slot, phase;
    logic [6:0] lit;
    logic       dot;
    logic [3:0] oh;
    logic       ft;
    e = '0;
    for (int w = 0; w < 3; w++) begin
      lit = '0; dot = 1'b0; oh = '0; ft = 1'b0;
      if (active) begin
        slot  = (tt / 8) % 4;
        phase = tt % 8;
        lit   = snap[slot];
        dot   = snap_dots[slot];
        if (w == 1 || phase >= 2) oh = 4'b0001 << slot;
        ft    = ((tt % 32) == 31);
      end
      if (w < 2) begin
        e.seg[w] = ~lit; e.dp[w] = ~dot; e.sel[w] = ~oh;
      end else begin
        e.seg[w] = lit;  e.dp[w] = dot;  e.sel[w] = oh;
      end
      e.ft[w] = ft;
    end
    return e;
  endfunction

  task automatic take_snap();
    snap[0] = d0; snap[1] = d1; snap[2] = d2; snap[3] = d3;
    snap_dots = dots;
  endtask

  // Drive one cycle of stimulus and queue the output expected after that edge.
  task automatic step(input logic r, input logic e, input logic [6:0] nd0);
    @(negedge clk);
    rst = r; en = e; d0 = nd0;
    if (!r || !e) begin
      q.push_back(build(1'b0, 0));
      run = 1'b0;
    end else if (!run) begin
      q.push_back(build(1'b0, 0));
      run = 1'b1;
      t = 0;
      take_snap();
    end else begin
      q.push_back(build(1'b1, t));
      if ((t % 32) == 31) take_snap();
      t++;
    end
  endtask

  task automatic chk(input string name, input int w, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %h, want %h", name, w, $time, act, req);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t ex;
    #1;
    if (q.size() != 0) begin
      ex = q.pop_front();
      chk("seg", 0, seg_a, ex.seg[0]);
      chk("dp", 0, {6'd0, dp_a}, {6'd0, ex.dp[0]});
      chk("sel", 0, {3'd0, sel_a}, {3'd0, ex.sel[0]});
      chk("frame_tick", 0, {6'd0, ft_a}, {6'd0, ex.ft[0]});
      chk("seg", 1, seg_z, ex.seg[1]);
      chk("dp", 1, {6'd0, dp_z}, {6'd0, ex.dp[1]});
      chk("sel", 1, {3'd0, sel_z}, {3'd0, ex.sel[1]});
      chk("frame_tick", 1, {6'd0, ft_z}, {6'd0, ex.ft[1]});
      chk("seg", 2, seg_h, ex.seg[2]);
      chk("dp", 2, {6'd0, dp_h}, {6'd0, ex.dp[2]});
      chk("sel", 2, {3'd0, sel_h}, {3'd0, ex.sel[2]});
      chk("frame_tick", 2, {6'd0, ft_h}, {6'd0, ex.ft[2]});
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1;
    d0 = 7'h3F; d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F;
    dots = 4'b0101;

    // Reset held with en high: outputs stay at the idle levels.
    repeat (3) step(1'b0, 1'b1, 7'h3F);

    // Scan two-plus frames; digit_0 changes during digit 1's slot (t=9),
    // so frame 0 keeps 3F and frames 1.. show 7F.  Loop ends in SHOW of
    // digit 2 in frame 2 (last t = 82).
    for (int i = 0; i < 84; i++) step(1'b1, 1'b1, (i >= 10) ? 7'h7F : 7'h3F);

    // Disable mid-SHOW, then disable together with reset.
    step(1'b1, 1'b0, 7'h3F);
    step(1'b1, 1'b0, 7'h3F);
    step(1'b0, 1'b0, 7'h3F);

    // Re-enable: restart at digit 0 with a fresh snapshot.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 7'h3F);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ssds_scan_driver.md
Name: ssds_scan_driver

Overview:
- Time-multiplexed display driver downstream of the SSD bus interface.
- Consumes its enable, four 7-segment digit patterns and four dot bits.
- Drives a physical 4-digit common-segment display: one shared segment bus plus four digit-select lines, scanned cyclically.
- Adds anti-ghosting blanking, frame-consistent snapshotting and selectable pin polarity.

Parameters:
- DIGIT_PERIOD, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); must be >= 2.
- BLANK_CYCLES, 500, leading cycles of each slot with all selects inactive; must be < DIGIT_PERIOD; 0 disables blanking.
- SEG_ACTIVE_LOW, 1, 1: seg/dp pins are low when lit.
- SEL_ACTIVE_LOW, 1, 1: sel pins are low when the digit is selected.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- en  in  1  display enable from bus interface
- digit_0..digit_3  in  7 each  segment patterns, bit0=a .. bit6=g, 1=lit
- dots  in  4  decimal points, bit i belongs to digit i, 1=lit
- seg  out  7  shared segment pins, polarity per SEG_ACTIVE_LOW
- dp  out  1  shared decimal-point pin, polarity per SEG_ACTIVE_LOW
- sel  out  4  digit-select pins, one-hot when active, polarity per SEL_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse on the last cycle of digit 3's slot

Behaviour:
- All outputs are registered and are updated only on the clk rising edge.
- rst is sampled only on the clk edge; when low, all state clears on that edge.
- Reset values:
  - state=IDLE, index=0, slot counter=0, shadow regs=0.
  - seg and dp at the unlit level (all 1s if SEG_ACTIVE_LOW).
  - sel at the deselected level (4'b1111 if SEL_ACTIVE_LOW).
  - frame_tick=0.
- States: IDLE, BLANK, SHOW.
  - IDLE: outputs unlit/deselected. When en=1, go to BLANK (or SHOW if BLANK_CYCLES=0) with index=0 and counter=0, and snapshot the inputs.
  - BLANK: sel deselected; seg/dp already carry digit[index]. When counter reaches BLANK_CYCLES-1, go to SHOW.
  - SHOW: sel[index] active, all other sel bits inactive. When counter reaches DIGIT_PERIOD-1: counter=0; index=(index+1) mod 4 (3 wraps to 0); go to BLANK (or SHOW if BLANK_CYCLES=0).
- Slot counter increments every cycle in BLANK/SHOW, spans 0..DIGIT_PERIOD-1, and its width is clog2(DIGIT_PERIOD).
- Snapshot: digit_0..3 and dots are copied into shadow registers on leaving IDLE and on every wrap from index 3 to 0. Input changes mid-frame therefore appear from the next frame only (no tearing).
- Output latency: outputs reflect the state/index registered one cycle earlier.
  - First sel assertion comes BLANK_CYCLES+1 cycles after en is sampled high.
  - Each digit is selected for exactly DIGIT_PERIOD-BLANK_CYCLES cycles per slot.
- frame_tick = 1 for one cycle, on the same edge that sel[3] is last driven active in a frame.
- en deassertion in any state: the next edge enters IDLE, forces outputs unlit/deselected, and clears index/counter. Re-enable always restarts at digit 0 with a fresh snapshot.
- Simultaneous en=0 and rst=0: reset wins; the result is identical.
- Polarity is applied only at the output register. Internal logic is active-high.
- At most one sel bit is ever active.
- While en=1 the design is free-running; there is no bus handshake.

Decomposition:
- Package ssds_pkg:
  - DIGIT_COUNT=4.
  - State enum {IDLE, BLANK, SHOW}.
  - Segment-bit index constants SEG_A..SEG_G.
  - Shared with the bus interface and the digit mapper.
- Sub-module ssds_slot_timer:
  - Parameterised modulo-DIGIT_PERIOD counter with clear/enable.
  - Outputs blank_done and slot_done strobes.
- The top holds the FSM, index, shadow registers and output registers.

Test Plan (DIGIT_PERIOD=8, BLANK_CYCLES=2, both polarities active-low):
- Reset held low 3 cycles with en=1 -> seg=7'h7F, dp=1, sel=4'hF, frame_tick=0 throughout; after release, first sel=4'hE appears 3 edges later.
- en=1; digit_0..3=7'h3F,7'h06,7'h5B,7'h4F; dots=4'b0101 -> sel walks E,D,B,7 with 6 active cycles per slot and 2 cycles at F between slots; seg=~pattern; dp=0 on digits 0 and 2; frame_tick pulses every 32 cycles.
- Change digit_0 to 7'h7F during digit 1's slot -> digit 0 keeps showing ~7'h3F until the next frame; from then on it shows 7'h00.
- Drop en during SHOW of digit 2 -> next edge gives sel=F and seg=7F; re-raise en -> scan restarts at digit 0 after 2 blank cycles.
- BLANK_CYCLES=0 -> no F gap between slots; each sel is active for 8 cycles.
- Active-high polarity build with the same data as the second scenario -> sel is one-hot 1,2,4,8; seg=pattern; idle sel=0, seg=0.
